// File: rtl/fa_pkg.sv
// Shared constants and helpers for the self-checking adder block.
package fa_pkg;

  localparam int unsigned FA_MAX_WIDTH = 64;

  function automatic bit fa_width_ok(input int unsigned w);
    return (w >= 1) && (w <= FA_MAX_WIDTH);
  endfunction

endpackage

// File: rtl/fa_gate_cell.sv
// Gate-level 1-bit full adder, one link of the ripple chain.
module fa_gate_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic w_axb;

  assign w_axb = a ^ b;
  assign s     = w_axb ^ ci;
  assign co    = (a & b) | (ci & w_axb);

endmodule

// File: rtl/full_adder_checked.sv
// Registered ripple-carry adder cross-checked against a behavioral sum every cycle.
module full_adder_checked
  import fa_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             c_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] s_out,
  output logic             c_out,
  output logic             mismatch,
  output logic             err_sticky
);

  typedef struct packed {
    logic             c;
    logic [WIDTH-1:0] s;
  } fa_result_t;

  if (!fa_width_ok(WIDTH)) begin : g_bad_width
    $error("full_adder_checked: WIDTH out of range");
  end

  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;
  fa_result_t       w_gate;
  fa_result_t       w_ref;
  logic             w_diff;

  logic             r_valid;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_mismatch;
  logic             r_err;

  assign w_carry[0] = c_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    fa_gate_cell u_cell (
      .a  (x[i]),
      .b  (y[i]),
      .ci (w_carry[i]),
      .s  (w_sum[i]),
      .co (w_carry[i+1])
    );
  end

  assign w_gate = '{c: w_carry[WIDTH], s: w_sum};
  assign w_ref  = fa_result_t'({1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c_in});

  // Case inequality so any X/Z on the gate path is flagged rather than masked.
  assign w_diff = (w_gate !== w_ref);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_sum      <= '0;
      r_carry    <= 1'b0;
      r_mismatch <= 1'b0;
      r_err      <= 1'b0;
    end else if (in_valid) begin
      r_valid    <= 1'b1;
      r_sum      <= w_gate.s;
      r_carry    <= w_gate.c;
      r_mismatch <= w_diff;
      r_err      <= r_err | w_diff;
    end else begin
      r_valid    <= 1'b0;
      r_mismatch <= 1'b0;
    end
  end

  assign out_valid  = r_valid;
  assign s_out      = r_sum;
  assign c_out      = r_carry;
  assign mismatch   = r_mismatch;
  assign err_sticky = r_err;

endmodule

// File: tb/tb_full_adder_checked.sv
// Directed bench for full_adder_checked at WIDTH=1 and WIDTH=8.
module tb_full_adder_checked;

  logic       clk;
  logic       rst_n;

  logic       in_v1, x1, y1, c1;
  logic       ov1, s1, co1, mm1, err1;

  logic       in_v8, c8;
  logic [7:0] x8, y8;
  logic       ov8, co8, mm8, err8;
  logic [7:0] s8;

  int n_cmp = 0;
  int n_err = 0;

  full_adder_checked #(.WIDTH(1)) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_v1),
    .x          (x1),
    .y          (y1),
    .c_in       (c1),
    .out_valid  (ov1),
    .s_out      (s1),
    .c_out      (co1),
    .mismatch   (mm1),
    .err_sticky (err1)
  );

  full_adder_checked #(.WIDTH(8)) dut8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_v8),
    .x          (x8),
    .y          (y8),
    .c_in       (c8),
    .out_valid  (ov8),
    .s_out      (s8),
    .c_out      (co8),
    .mismatch   (mm8),
    .err_sticky (err8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all1(input string tag, input logic v, input logic s, input logic c,
                            input logic m, input logic e);
    check({tag, ".valid"}, 64'(ov1), 64'(v));
    check({tag, ".s"}, 64'(s1), 64'(s));
    check({tag, ".c"}, 64'(co1), 64'(c));
    check({tag, ".mm"}, 64'(mm1), 64'(m));
    check({tag, ".err"}, 64'(err1), 64'(e));
  endtask

  task automatic check_all8(input string tag, input logic v, input logic [7:0] s, input logic c,
                            input logic m, input logic e);
    check({tag, ".valid"}, 64'(ov8), 64'(v));
    check({tag, ".s"}, 64'(s8), 64'(s));
    check({tag, ".c"}, 64'(co8), 64'(c));
    check({tag, ".mm"}, 64'(mm8), 64'(m));
    check({tag, ".err"}, 64'(err8), 64'(e));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] tt_s;
    logic [7:0] tt_c;
    logic [8:0] exp9;
    tt_s = 8'b1001_0110;
    tt_c = 8'b1110_1000;

    rst_n = 1'b0;
    in_v1 = 1'b0; x1 = 1'b0; y1 = 1'b0; c1 = 1'b0;
    in_v8 = 1'b0; x8 = '0; y8 = '0; c8 = 1'b0;

    #2;
    check_all1("rst1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_all8("rst8", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Exhaustive 1-bit truth table, back to back.
    for (int i = 0; i < 8; i++) begin
      {x1, y1, c1} = 3'(i);
      in_v1 = 1'b1;
      tick();
      check_all1($sformatf("tt%0d", i), 1'b1, tt_s[i], tt_c[i], 1'b0, 1'b0);
    end

    // Hold: accept 1+0+0 then idle three cycles.
    x1 = 1'b1; y1 = 1'b0; c1 = 1'b0; in_v1 = 1'b1;
    tick();
    check_all1("hold_ld", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    in_v1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all1($sformatf("hold%0d", i), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    end

    // Asynchronous reset mid-cycle with s_out=1 held.
    #2 rst_n = 1'b0;
    #1;
    check_all1("arst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    x1 = 1'b1; y1 = 1'b1; c1 = 1'b0; in_v1 = 1'b1;
    tick();
    check_all1("post_rst", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    in_v1 = 1'b0;

    // WIDTH=8 wrap-around.
    x8 = 8'hFF; y8 = 8'h01; c8 = 1'b0; in_v8 = 1'b1;
    tick();
    check_all8("wrap0", 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    x8 = 8'hFF; y8 = 8'hFF; c8 = 1'b1;
    tick();
    check_all8("wrap1", 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);

    // Back-to-back random operands.
    for (int i = 0; i < 100; i++) begin
      x8 = 8'($urandom_range(0, 255));
      y8 = 8'($urandom_range(0, 255));
      c8 = 1'($urandom_range(0, 1));
      exp9 = {1'b0, x8} + {1'b0, y8} + {8'h00, c8};
      tick();
      check($sformatf("rnd%0d.s", i), 64'(s8), 64'(exp9[7:0]));
      check($sformatf("rnd%0d.c", i), 64'(co8), 64'(exp9[8]));
      check($sformatf("rnd%0d.valid", i), 64'(ov8), 64'd1);
      check($sformatf("rnd%0d.err", i), 64'(err8), 64'd0);
    end

    // Fault injection on bit 0's sum for one vector.
    x8 = 8'h00; y8 = 8'h00; c8 = 1'b0;
    force dut8.g_bit[0].u_cell.s = 1'b1;
    tick();
    release dut8.g_bit[0].u_cell.s;
    check_all8("fault", 1'b1, 8'h01, 1'b0, 1'b1, 1'b1);
    x8 = 8'h10; y8 = 8'h22; c8 = 1'b1;
    tick();
    check_all8("after_fault", 1'b1, 8'h33, 1'b0, 1'b0, 1'b1);
    in_v8 = 1'b0;
    repeat (2) tick();
    check_all8("sticky_idle", 1'b0, 8'h33, 1'b0, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_all8("sticky_clr", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/full_adder_checked.md
Name: full_adder_checked

Overview:
- Registered adder block for the datapath.
- Computes x + y + c_in two independent ways:
  - a gate-level ripple chain of 1-bit full-adder cells;
  - a behavioral arithmetic reference.
- Registers the gate-level result and flags any disagreement between the two.
- With WIDTH=1 it is a clocked, self-checking 1-bit full adder.

Parameters:
- WIDTH, 1, operand width in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands are valid this cycle
- x  input  WIDTH  operand A
- y  input  WIDTH  operand B
- c_in  input  1  carry in
- out_valid  output  1  registered result valid
- s_out  output  WIDTH  registered sum
- c_out  output  1  registered carry out
- mismatch  output  1  gate-level and behavioral results differed for the current output
- err_sticky  output  1  set on any mismatch; cleared only by reset

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- While rst_n=0, all outputs are 0: out_valid, s_out, c_out, mismatch, err_sticky.
- Per-bit gate-level cell:
  - s = a ^ b ^ ci
  - co = (a & b) | (ci & (a ^ b))
- Ripple chain:
  - bit 0 takes c_in;
  - each bit's co feeds the next bit's ci;
  - the MSB co is the chain carry.
- Behavioral reference: {carry, sum} = x + y + c_in, evaluated at WIDTH+1 bits so no bits are lost.
- Latency is 1 cycle. On the rising edge with in_valid=1:
  - s_out and c_out load the gate-level result;
  - out_valid goes to 1;
  - mismatch loads (gate result != behavioral result);
  - err_sticky becomes err_sticky | that compare.
- On a rising edge with in_valid=0:
  - out_valid goes to 0;
  - s_out and c_out hold their previous values;
  - mismatch goes to 0;
  - err_sticky holds.
- No backpressure. A new operand set may be accepted every cycle; each result appears exactly one cycle later.
- Wrap-around: maximum operands plus c_in=1 give s_out all ones and c_out=1. There is no overflow beyond c_out.
- Reset asserted mid-stream clears all outputs immediately, with no clock needed. The first valid input after reset release produces a result one edge later.
- Inputs that are X/Z are the environment's responsibility. The compare treats any non-0/1 bit as a mismatch, using a case-inequality comparison.

Decomposition:
- Shared package fa_pkg holds:
  - localparam FA_MAX_WIDTH = 64;
  - a packed struct fa_result_t {logic c; logic [WIDTH-1:0] s}, with width supplied via parameterised use or a typedef per instance.
- One sub-module, fa_gate_cell:
  - purely combinational gate-level 1-bit full adder;
  - ports a, b, ci, s, co;
  - instantiated WIDTH times with a generate loop.
- The behavioral reference, the compare and the output registers live in full_adder_checked.

Test Plan:
- Exhaustive truth table, WIDTH=1, one vector per cycle with in_valid=1, driving (x,y,c_in) from 000 through 111. One cycle later (s_out,c_out) must equal, in order: (0,0) (1,0) (1,0) (0,1) (1,0) (0,1) (0,1) (1,1). mismatch=0 and err_sticky=0 throughout.
- Reset values: drive rst_n=0 asynchronously mid-cycle after a valid result, for example s_out=1. All outputs drop to 0 immediately, before the next clk edge.
- Hold behaviour: after x=1, y=0, c_in=0 is accepted, drop in_valid for 3 cycles. out_valid=0 while s_out=1 and c_out=0 hold.
- Wrap-around, WIDTH=8: x=8'hFF, y=8'h01, c_in=0 gives s_out=8'h00, c_out=1. Then x=8'hFF, y=8'hFF, c_in=1 gives s_out=8'hFF, c_out=1.
- Back-to-back throughput, WIDTH=8: 100 random operand sets, one per cycle. Every output matches (x+y+c_in) one cycle later, with out_valid continuously 1 and err_sticky=0.
- Fault injection: force one fa_gate_cell s output to the wrong value for a single vector. mismatch=1 for that result cycle; err_sticky=1 persists until rst_n=0.
